aibio_cdr_pi_ctrl: RTL

// - Closed-loop CDR phase controller for the RX DLL. Consumes the bang-bang phase-detect

---
 rtl/aibio_cdr_pkg.sv | 23 ++
 rtl/aibio_cdr_vote_acc.sv | 78 +++++++
 rtl/aibio_cdr_pi_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/aibio_cdr_pkg.sv
// Shared types for the CDR phase-interpolator controller.
//   cdr_st_e  : controller FSM states
//   cdr_dec_e : per-window vote decision
package aibio_cdr_pkg;

  localparam int unsigned CDR_ST_W  = 3;
  localparam int unsigned CDR_DEC_W = 2;

  typedef enum logic [CDR_ST_W-1:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    ACCUM  = 3'd3,
    DECIDE = 3'd4
  } cdr_st_e;

  typedef enum logic [CDR_DEC_W-1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } cdr_dec_e;

endpackage

// File: rtl/aibio_cdr_vote_acc.sv
// Phase-detect vote accumulator: 2-flop synchronizer, ACC_N-sample ones counter and
// threshold compare.
//   clk_int, rstb : clock, async active-low reset
//   phdet         : raw bang-bang sample
//   acc_en        : count this cycle (controller in ACCUM)
//   clr           : abandon the current window
//   acc_last_c    : this cycle takes the last sample of the window
//   done          : decision valid (one cycle, follows the last sample)
//   dec           : decision of the completed window
module aibio_cdr_vote_acc
  import aibio_cdr_pkg::*;
#(
  parameter int unsigned ACC_N   = 16,
  parameter int unsigned VOTE_HI = 11,
  parameter int unsigned VOTE_LO = 5
) (
  input  logic     clk_int,
  input  logic     rstb,
  input  logic     phdet,
  input  logic     acc_en,
  input  logic     clr,
  output logic     acc_last_c,
  output logic     done,
  output cdr_dec_e dec
);

  localparam int unsigned ONES_W = $clog2(ACC_N + 1);
  localparam int unsigned SMP_W  = $clog2(ACC_N);

  logic [1:0]        sync_q;
  logic              sync_phdet;
  logic [SMP_W-1:0]  smp_cnt_q;
  logic [ONES_W-1:0] ones_q;
  logic [ONES_W-1:0] ones_sum_c;
  cdr_dec_e          dec_c;

  assign sync_phdet = sync_q[1];
  assign acc_last_c = acc_en && (smp_cnt_q == SMP_W'(ACC_N - 1));
  assign ones_sum_c = ones_q + ONES_W'(sync_phdet);

  // Threshold on the full window count, including the sample taken this cycle.
  always_comb begin
    dec_c = HOLD;
    if (ones_sum_c >= ONES_W'(VOTE_HI)) begin
      dec_c = DEC;
    end else if (ones_sum_c <= ONES_W'(VOTE_LO)) begin
      dec_c = INC;
    end
  end

  always_ff @(posedge clk_int or negedge rstb) begin
    if (!rstb) begin
      sync_q    <= 2'b00;
      smp_cnt_q <= '0;
      ones_q    <= '0;
      done      <= 1'b0;
      dec       <= HOLD;
    end else begin
      sync_q <= {sync_q[0], phdet};
      done   <= 1'b0;
      if (clr) begin
        smp_cnt_q <= '0;
        ones_q    <= '0;
      end else if (acc_en) begin
        if (acc_last_c) begin
          smp_cnt_q <= '0;
          ones_q    <= '0;
          done      <= 1'b1;
          dec       <= dec_c;
        end else begin
          smp_cnt_q <= smp_cnt_q + SMP_W'(1);
          ones_q    <= ones_sum_c;
        end
      end
    end
  end

endmodule

// File: rtl/aibio_cdr_pi_ctrl.sv
// Closed-loop CDR phase controller: votes phase-detect windows, steps the PI code
// circularly, waits for the DLL to settle after each step, and tracks lock.
//   clk_int, rstb : clock, async active-low reset
//   i_en          : loop enable (level); rising edge reloads i_code_init
//   i_freeze      : hold the code; votes and lock tracking continue
//   i_code_init   : code loaded on enable
//   i_phdet       : bang-bang phase-detect sample
//   o_pi_code     : interpolator code
//   o_pi_upd      : one-cycle strobe when o_pi_code changes
//   o_cdr_lock    : loop locked
//   o_busy        : controller not idle
module aibio_cdr_pi_ctrl
  import aibio_cdr_pkg::*;
#(
  parameter int unsigned PI_W       = 7,
  parameter int unsigned ACC_N      = 16,
  parameter int unsigned VOTE_HI    = 11,
  parameter int unsigned VOTE_LO    = 5,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned LOCK_N     = 4,
  parameter int unsigned LOSS_N     = 3
) (
  input  logic            clk_int,
  input  logic            rstb,
  input  logic            i_en,
  input  logic            i_freeze,
  input  logic [PI_W-1:0] i_code_init,
  input  logic            i_phdet,
  output logic [PI_W-1:0] o_pi_code,
  output logic            o_pi_upd,
  output logic            o_cdr_lock,
  output logic            o_busy
);

  localparam int unsigned SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned HOLD_W = $clog2(LOCK_N + 1);
  localparam int unsigned STEP_W = $clog2(LOSS_N + 1);

  if (!(VOTE_LO < VOTE_HI && VOTE_HI <= ACC_N && ACC_N >= 2 && SETTLE_CYC >= 1 &&
        LOCK_N >= 1 && LOSS_N >= 1)) begin : g_param_chk
    $error("aibio_cdr_pi_ctrl: illegal parameter set");
  end

  cdr_st_e           state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [PI_W-1:0]   code_q, code_d;
  logic              upd_q, upd_d;
  logic              lock_q, lock_d;
  logic              busy_q;

  logic     acc_last_c;
  logic     vote_done;
  cdr_dec_e vote_dec;

  aibio_cdr_vote_acc #(
    .ACC_N   (ACC_N),
    .VOTE_HI (VOTE_HI),
    .VOTE_LO (VOTE_LO)
  ) u_vote (
    .clk_int    (clk_int),
    .rstb       (rstb),
    .phdet      (i_phdet),
    .acc_en     (state_q == ACCUM),
    .clr        (!i_en),
    .acc_last_c (acc_last_c),
    .done       (vote_done),
    .dec        (vote_dec)
  );

  // Next-state, code and lock bookkeeping.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    hold_d   = hold_q;
    step_d   = step_q;
    code_d   = code_q;
    upd_d    = 1'b0;
    lock_d   = lock_q;

    unique case (state_q)
      IDLE: begin
        if (i_en) state_d = LOAD;
      end
      LOAD: begin
        code_d   = i_code_init;
        upd_d    = 1'b1;
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          settle_d = '0;
          state_d  = ACCUM;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ACCUM: begin
        if (acc_last_c) state_d = DECIDE;
      end
      DECIDE: begin
        state_d = ACCUM;
        if (vote_done) begin
          if (vote_dec == HOLD) begin
            step_d = '0;
            if (hold_q != HOLD_W'(LOCK_N)) hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_W'(LOCK_N - 1)) lock_d = 1'b1;
          end else begin
            hold_d = '0;
            // A frozen step still counts against lock.
            if (lock_q) begin
              if (step_q == STEP_W'(LOSS_N - 1)) begin
                lock_d = 1'b0;
                step_d = '0;
              end else begin
                step_d = step_q + STEP_W'(1);
              end
            end
            if (!i_freeze) begin
              code_d  = (vote_dec == INC) ? code_q + PI_W'(1) : code_q - PI_W'(1);
              upd_d   = 1'b1;
              state_d = SETTLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable wins from any state; the code is retained.
    if (!i_en) begin
      state_d  = IDLE;
      settle_d = '0;
      hold_d   = '0;
      step_d   = '0;
      lock_d   = 1'b0;
      upd_d    = 1'b0;
      code_d   = code_q;
    end
  end

  always_ff @(posedge clk_int or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      settle_q <= '0;
      hold_q   <= '0;
      step_q   <= '0;
      code_q   <= '0;
      upd_q    <= 1'b0;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      code_q   <= code_d;
      upd_q    <= upd_d;
      lock_q   <= lock_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign o_pi_code  = code_q;
  assign o_pi_upd   = upd_q;
  assign o_cdr_lock = lock_q;
  assign o_busy     = busy_q;

endmodule
